// File: rtl/adder_bist_if.sv
// Bus between the adder BIST controller and its environment.
// Handshake: start is a level request; the controller only samples it while
// idle or done, otherwise it is ignored. done is a level that holds, and pass
// is meaningful only while done=1. Operands are registered by the controller.
// The adder's response (sum_in/cout_in) is captured at the next rising edge.
interface adder_bist_if;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_cin;
  logic [31:0] sum_in;
  logic        cout_in;
  logic        busy;
  logic        done;
  logic        pass;
  logic [32:0] signature;
  logic [15:0] pattern_cnt;
  logic [2:0]  state_dbg;

  // Controller side.
  modport master (
    input  start, sum_in, cout_in,
    output op_a, op_b, op_cin, busy, done, pass, signature, pattern_cnt, state_dbg
  );

  // Environment side: the requester plus the adder under test.
  modport slave (
    output start, sum_in, cout_in,
    input  op_a, op_b, op_cin, busy, done, pass, signature, pattern_cnt, state_dbg
  );
endinterface

// File: rtl/adder_bist_ctrl.sv
// BIST controller for a 32-bit ripple-carry adder: applies one full-carry-chain
// pattern, then LFSR patterns, compacts each 33-bit response into a MISR and
// compares the final signature against a golden value.
module adder_bist_ctrl #(
  parameter int          N_PATTERNS = 256,
  parameter logic [31:0] SEED_A     = 32'hACE1_0001,
  parameter logic [31:0] SEED_B     = 32'h1234_5679,
  parameter logic [32:0] GOLDEN_SIG = 33'h1_0000_0000
) (
  input logic          clk,
  input logic          rst,
  adder_bist_if.master bus
);

  // Reject illegal configurations at elaboration time.
  generate
    if (N_PATTERNS < 1 || N_PATTERNS > 65535) begin : g_bad_npat
      $error("adder_bist_ctrl: N_PATTERNS must be in 1..65535");
    end
    if (SEED_A == 32'd0 || SEED_B == 32'd0) begin : g_bad_seed
      $error("adder_bist_ctrl: LFSR seeds must be nonzero");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEED = 3'd1,
    S_RUN  = 3'd2,
    S_CMP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(N_PATTERNS - 1);

  state_t      r_state;
  logic [31:0] r_lfsr_a;
  logic [31:0] r_lfsr_b;
  logic [32:0] r_misr;
  logic [15:0] r_cnt;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic        r_op_cin;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;

  logic        w_misr_fb;
  logic [32:0] w_misr_nxt;
  logic [31:0] w_lfsr_a_nxt;
  logic [31:0] w_lfsr_b_nxt;
  logic [15:0] w_cnt_nxt;

  // MISR fold of the current adder response, and the next LFSR/counter values.
  assign w_misr_fb    = r_misr[32] ^ r_misr[12];
  assign w_misr_nxt   = {r_misr[31:0], w_misr_fb} ^ {bus.cout_in, bus.sum_in};
  assign w_lfsr_a_nxt = {r_lfsr_a[30:0], r_lfsr_a[31] ^ r_lfsr_a[21] ^ r_lfsr_a[1] ^ r_lfsr_a[0]};
  assign w_lfsr_b_nxt = {r_lfsr_b[30:0], r_lfsr_b[31] ^ r_lfsr_b[21] ^ r_lfsr_b[1] ^ r_lfsr_b[0]};
  assign w_cnt_nxt    = r_cnt + 16'd1;

  // Sequencer: state, pattern generation, response compaction and verdict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_lfsr_a <= '0;
      r_lfsr_b <= '0;
      r_misr   <= '0;
      r_cnt    <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_op_cin <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state <= S_SEED;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
          end
        end
        S_SEED: begin
          // Pattern 0 exercises the whole carry chain: all-ones + 0 + cin=1.
          r_lfsr_a <= SEED_A;
          r_lfsr_b <= SEED_B;
          r_misr   <= '0;
          r_cnt    <= '0;
          r_op_a   <= 32'hFFFF_FFFF;
          r_op_b   <= 32'h0000_0000;
          r_op_cin <= 1'b1;
          r_state  <= S_RUN;
        end
        S_RUN: begin
          r_misr <= w_misr_nxt;
          if (r_cnt == LAST_IDX) begin
            r_state <= S_CMP;
          end else begin
            r_op_a   <= r_lfsr_a;
            r_op_b   <= r_lfsr_b;
            r_op_cin <= w_cnt_nxt[0];
            r_lfsr_a <= w_lfsr_a_nxt;
            r_lfsr_b <= w_lfsr_b_nxt;
            r_cnt    <= w_cnt_nxt;
          end
        end
        S_CMP: begin
          r_pass  <= (r_misr == GOLDEN_SIG);
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.op_a        = r_op_a;
  assign bus.op_b        = r_op_b;
  assign bus.op_cin      = r_op_cin;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.pass        = r_pass;
  assign bus.signature   = r_misr;
  assign bus.pattern_cnt = r_cnt;
  assign bus.state_dbg   = r_state;

endmodule

// File: tb/tb_adder_bist_ctrl.sv
// Bench for adder_bist_ctrl: a 1-pattern instance (with an optional carry
// fault in its adder) and a 256-pattern instance checked against a reference
// model of the LFSR patterns and MISR signature.
module tb_adder_bist_ctrl;
  localparam int          NB     = 256;
  localparam logic [31:0] SEED_A = 32'hACE1_0001;
  localparam logic [31:0] SEED_B = 32'h1234_5679;
  localparam logic [32:0] GOLDEN = 33'h1_0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_bist_if ifa ();
  adder_bist_if ifb ();

  int tests_run    = 0;
  int tests_failed = 0;

  // Adder for instance A, with a selectable stuck-at-0 carry between bit 15 and 16.
  logic        fault_a = 1'b0;
  logic [16:0] lo_a;
  logic [16:0] hi_a;
  assign lo_a = {1'b0, ifa.op_a[15:0]} + {1'b0, ifa.op_b[15:0]} + {16'd0, ifa.op_cin};
  assign hi_a = {1'b0, ifa.op_a[31:16]} + {1'b0, ifa.op_b[31:16]} + {16'd0, lo_a[16] & ~fault_a};
  assign ifa.sum_in  = {hi_a[15:0], lo_a[15:0]};
  assign ifa.cout_in = hi_a[16];

  // Ideal adder for instance B.
  assign {ifb.cout_in, ifb.sum_in} = {1'b0, ifb.op_a} + {1'b0, ifb.op_b} + {32'd0, ifb.op_cin};

  adder_bist_ctrl #(.N_PATTERNS(1)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.master)
  );

  adder_bist_ctrl #(
    .N_PATTERNS (NB),
    .SEED_A     (SEED_A),
    .SEED_B     (SEED_B),
    .GOLDEN_SIG (GOLDEN)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.master)
  );

  // ---------------- reference model ----------------
  logic [64:0] exp_q[$];   // {op_a, op_b, op_cin} per pattern
  logic [32:0] exp_sig;
  logic [32:0] last_sig;

  function automatic logic [31:0] lfsr_step(input logic [31:0] q);
    return {q[30:0], q[31] ^ q[21] ^ q[1] ^ q[0]};
  endfunction

  function automatic void build_model(input int n);
    logic [31:0] la, lb, a, b;
    logic        c;
    logic [32:0] m, resp;
    exp_q.delete();
    la = SEED_A;
    lb = SEED_B;
    m  = '0;
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        a = 32'hFFFF_FFFF; b = 32'd0; c = 1'b1;
      end else begin
        a = la; b = lb; c = k[0];
        la = lfsr_step(la);
        lb = lfsr_step(lb);
      end
      exp_q.push_back({a, b, c});
      resp = {1'b0, a} + {1'b0, b} + {32'd0, c};
      m = {m[31:0], m[32] ^ m[12]} ^ resp;
    end
    exp_sig = m;
  endfunction

  // ---------------- driver tasks ----------------
  function automatic logic busy_of(input int which);
    return (which == 0) ? ifa.busy : ifb.busy;
  endfunction

  function automatic logic done_of(input int which);
    return (which == 0) ? ifa.done : ifb.done;
  endfunction

  task automatic set_start(input int which, input logic v);
    if (which == 0) ifa.start = v; else ifb.start = v;
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(0, 4)) @(negedge clk);
  endtask

  // Pulse start, then wait (bounded) for done. edges counts negedges after the
  // sampling edge; busy_cnt counts cycles with busy observed high.
  task automatic run_inst(input int which, input bit rand_start, input int n_pat,
                          output int edges, output int busy_cnt);
    set_start(which, 1'b1);
    @(negedge clk);
    set_start(which, 1'b0);
    edges    = 1;
    busy_cnt = (busy_of(which) === 1'b1) ? 1 : 0;
    while (done_of(which) !== 1'b1 && edges < n_pat + 20) begin
      if (rand_start && edges < n_pat) set_start(which, 1'($urandom_range(0, 1)));
      else set_start(which, 1'b0);
      @(negedge clk);
      edges++;
      if (busy_of(which) === 1'b1) busy_cnt++;
    end
    set_start(which, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({ifa.busy, ifa.done, ifa.pass, ifa.signature, ifa.pattern_cnt, ifa.op_a, ifa.op_b, ifa.op_cin} !== '0) begin
      tests_failed++;
      $display("FAIL reset_a: outputs %h, expected all zero",
               {ifa.busy, ifa.done, ifa.pass, ifa.signature, ifa.pattern_cnt, ifa.op_a, ifa.op_b, ifa.op_cin});
    end
    tests_run++;
    if ({ifb.busy, ifb.done, ifb.pass, ifb.signature, ifb.pattern_cnt, ifb.op_a, ifb.op_b, ifb.op_cin} !== '0) begin
      tests_failed++;
      $display("FAIL reset_b: outputs %h, expected all zero",
               {ifb.busy, ifb.done, ifb.pass, ifb.signature, ifb.pattern_cnt, ifb.op_a, ifb.op_b, ifb.op_cin});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_ideal();
    int edges, busy_cnt;
    fault_a = 1'b0;
    idle_gap();
    run_inst(0, 1'b0, 1, edges, busy_cnt);
    tests_run++;
    if (edges - 1 != 3) begin
      tests_failed++; $display("FAIL single_latency: got %0d edges, expected 3", edges - 1);
    end
    tests_run++;
    if (busy_cnt != 3) begin
      tests_failed++; $display("FAIL single_busy_cycles: got %0d, expected 3", busy_cnt);
    end
    tests_run++;
    if ({ifa.done, ifa.busy} !== 2'b10) begin
      tests_failed++; $display("FAIL single_done_busy: got %b, expected 10", {ifa.done, ifa.busy});
    end
    tests_run++;
    if ({ifa.op_a, ifa.op_b, ifa.op_cin} !== {32'hFFFF_FFFF, 32'd0, 1'b1}) begin
      tests_failed++; $display("FAIL single_operands: got %h %h %b, expected FFFFFFFF 00000000 1",
                               ifa.op_a, ifa.op_b, ifa.op_cin);
    end
    tests_run++;
    if (ifa.signature !== 33'h1_0000_0000) begin
      tests_failed++; $display("FAIL single_sig: got %h, expected 100000000", ifa.signature);
    end
    tests_run++;
    if (ifa.pass !== 1'b1) begin
      tests_failed++; $display("FAIL single_pass: got %b, expected 1", ifa.pass);
    end
  endtask

  task automatic test_single_fault();
    int edges, busy_cnt;
    fault_a = 1'b1;
    idle_gap();
    run_inst(0, 1'b0, 1, edges, busy_cnt);
    tests_run++;
    if (ifa.done !== 1'b1 || edges - 1 != 3) begin
      tests_failed++; $display("FAIL fault_done: done %b after %0d edges, expected 1 after 3", ifa.done, edges - 1);
    end
    tests_run++;
    if (ifa.signature !== 33'h0_FFFF_0000) begin
      tests_failed++; $display("FAIL fault_sig: got %h, expected 0FFFF0000", ifa.signature);
    end
    tests_run++;
    if (ifa.pass !== 1'b0) begin
      tests_failed++; $display("FAIL fault_pass: got %b, expected 0", ifa.pass);
    end
    fault_a = 1'b0;
  endtask

  task automatic test_full_run();
    logic [64:0] exp;
    int busy_cnt;
    build_model(NB);
    idle_gap();
    ifb.start = 1'b1;
    @(negedge clk);
    ifb.start = 1'b0;
    busy_cnt = (ifb.busy === 1'b1) ? 1 : 0;
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      if (ifb.busy === 1'b1) busy_cnt++;
      exp = exp_q.pop_front();
      tests_run++;
      if ({ifb.op_a, ifb.op_b, ifb.op_cin} !== exp || ifb.pattern_cnt !== 16'(k)) begin
        tests_failed++;
        $display("FAIL full_pattern[%0d]: got cnt %0d ops %h, expected ops %h", k, ifb.pattern_cnt,
                 {ifb.op_a, ifb.op_b, ifb.op_cin}, exp);
      end
    end
    @(negedge clk);
    if (ifb.busy === 1'b1) busy_cnt++;
    tests_run++;
    if (ifb.done !== 1'b0) begin
      tests_failed++; $display("FAIL full_early_done: got done %b in compare cycle, expected 0", ifb.done);
    end
    @(negedge clk);
    tests_run++;
    if ({ifb.done, ifb.busy} !== 2'b10) begin
      tests_failed++; $display("FAIL full_done_busy: got %b, expected 10", {ifb.done, ifb.busy});
    end
    tests_run++;
    if (busy_cnt != NB + 2) begin
      tests_failed++; $display("FAIL full_busy_cycles: got %0d, expected %0d", busy_cnt, NB + 2);
    end
    tests_run++;
    if (ifb.signature !== exp_sig) begin
      tests_failed++; $display("FAIL full_sig: got %h, expected %h", ifb.signature, exp_sig);
    end
    tests_run++;
    if (ifb.pass !== (exp_sig == GOLDEN)) begin
      tests_failed++; $display("FAIL full_pass: got %b, expected %b", ifb.pass, exp_sig == GOLDEN);
    end
    tests_run++;
    if (ifb.pattern_cnt !== 16'(NB - 1)) begin
      tests_failed++; $display("FAIL full_cnt_end: got %0d, expected %0d", ifb.pattern_cnt, NB - 1);
    end
    last_sig = ifb.signature;
  endtask

  task automatic test_reset_mid_run(input int target);
    int guard;
    int edges;
    idle_gap();
    ifb.start = 1'b1;
    @(negedge clk);
    ifb.start = 1'b0;
    guard = 0;
    while (ifb.pattern_cnt !== 16'(target) && guard < NB + 10) begin
      @(negedge clk);
      guard++;
    end
    tests_run++;
    if (ifb.pattern_cnt !== 16'(target)) begin
      tests_failed++; $display("FAIL midrst_reach: got cnt %0d, expected %0d", ifb.pattern_cnt, target);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({ifb.busy, ifb.done, ifb.pass, ifb.signature, ifb.pattern_cnt, ifb.op_a, ifb.op_b, ifb.op_cin} !== '0) begin
      tests_failed++;
      $display("FAIL midrst_async_clear[%0d]: outputs %h, expected all zero", target,
               {ifb.busy, ifb.done, ifb.pass, ifb.signature, ifb.pattern_cnt, ifb.op_a, ifb.op_b, ifb.op_cin});
    end
    // Release reset with start already high: first clean edge samples it.
    @(negedge clk);
    rst = 1'b0;
    ifb.start = 1'b1;
    @(negedge clk);
    ifb.start = 1'b0;
    tests_run++;
    if (ifb.busy !== 1'b1) begin
      tests_failed++; $display("FAIL midrst_start_at_release: got busy %b, expected 1", ifb.busy);
    end
    edges = 1;
    while (ifb.done !== 1'b1 && edges < NB + 20) begin
      @(negedge clk);
      edges++;
    end
    tests_run++;
    if (ifb.done !== 1'b1 || edges - 1 != NB + 2) begin
      tests_failed++; $display("FAIL midrst_rerun_len: done %b after %0d edges, expected 1 after %0d",
                               ifb.done, edges - 1, NB + 2);
    end
    tests_run++;
    if (ifb.signature !== exp_sig) begin
      tests_failed++; $display("FAIL midrst_sig[%0d]: got %h, expected %h", target, ifb.signature, exp_sig);
    end
  endtask

  task automatic test_start_during_run();
    int edges, busy_cnt;
    idle_gap();
    run_inst(1, 1'b1, NB, edges, busy_cnt);
    tests_run++;
    if (edges - 1 != NB + 2 || busy_cnt != NB + 2) begin
      tests_failed++; $display("FAIL start_noise_len: got %0d edges %0d busy, expected %0d", edges - 1, busy_cnt, NB + 2);
    end
    tests_run++;
    if (ifb.signature !== exp_sig) begin
      tests_failed++; $display("FAIL start_noise_sig: got %h, expected %h", ifb.signature, exp_sig);
    end
    tests_run++;
    if (ifb.pattern_cnt !== 16'(NB - 1)) begin
      tests_failed++; $display("FAIL start_noise_cnt: got %0d, expected %0d", ifb.pattern_cnt, NB - 1);
    end
  endtask

  task automatic test_back_to_back();
    int edges, busy_cnt;
    // Immediate restart from DONE, no idle gap.
    run_inst(1, 1'b0, NB, edges, busy_cnt);
    tests_run++;
    if (ifb.done !== 1'b1 || edges - 1 != NB + 2) begin
      tests_failed++; $display("FAIL b2b_len: done %b after %0d edges, expected 1 after %0d", ifb.done, edges - 1, NB + 2);
    end
    tests_run++;
    if (ifb.signature !== last_sig || ifb.signature !== exp_sig) begin
      tests_failed++; $display("FAIL b2b_sig: got %h, expected %h", ifb.signature, exp_sig);
    end
    tests_run++;
    if (ifb.pass !== (exp_sig == GOLDEN)) begin
      tests_failed++; $display("FAIL b2b_pass: got %b, expected %b", ifb.pass, exp_sig == GOLDEN);
    end
  endtask

  initial begin
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    test_reset();
    test_single_ideal();
    test_single_fault();
    test_single_ideal();
    test_full_run();
    test_reset_mid_run(100);
    test_reset_mid_run(int'($urandom_range(1, NB - 2)));
    test_start_during_run();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/adder_bist_ctrl.md
# adder_bist_ctrl

Built-in self-test controller for the 32-bit ripple-carry adder. It drives the adder's operand and carry-in inputs with a directed full-carry-chain pattern followed by LFSR pseudo-random patterns. It compacts each 33-bit response (sum plus carry-out) into a MISR signature and compares the final signature against a golden value. It sits directly upstream and downstream of the adder: it feeds the adder's inputs and consumes its outputs.

## Interface
- N_PATTERNS, 256: total patterns applied, including the directed pattern 0. Legal range 1..65535; elaboration fails outside it.
- SEED_A, 32'hACE1_0001: LFSR A seed. Must be nonzero.
- SEED_B, 32'h1234_5679: LFSR B seed. Must be nonzero.
- GOLDEN_SIG, 33'h1_0000_0000: expected final MISR value.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request, sampled in IDLE and DONE only.
- op_a  out  32  adder operand A (registered).
- op_b  out  32  adder operand B (registered).
- op_cin  out  1  adder carry-in (registered).
- sum_in  in  32  adder sum.
- cout_in  in  1  adder carry-out.
- busy  out  1  high in SEED, RUN and CMP.
- done  out  1  level; high in DONE.
- pass  out  1  valid while done=1.
- signature  out  33  MISR contents.
- pattern_cnt  out  16  index of the pattern currently applied.

## Operation
- Reset: all outputs go to 0, state IDLE, both LFSRs and the MISR go to 0.
- FSM states: IDLE, SEED, RUN, CMP, DONE.
- IDLE: start=1 moves to SEED.
- DONE: start=1 moves to SEED. done and pass hold until then.
- SEED (1 cycle):
  - LFSR A loads SEED_A; LFSR B loads SEED_B; MISR and pattern_cnt clear.
  - op_a loads 32'hFFFF_FFFF, op_b loads 0, op_cin loads 1 (pattern 0, the full-carry-chain pattern).
  - Next state RUN.
- RUN: one pattern per cycle. At each edge:
  - MISR absorbs the current response: fb = m[32]^m[12]; m <= {m[31:0], fb} ^ {cout_in, sum_in}.
  - If pattern_cnt = N_PATTERNS-1, move to CMP and leave the operands unchanged.
  - Otherwise:
    - op_a <= LFSR A, op_b <= LFSR B, op_cin <= next pattern_cnt[0].
    - Both LFSRs step (Fibonacci, x^32+x^22+x^2+x+1): q <= {q[30:0], q[31]^q[21]^q[1]^q[0]}.
    - pattern_cnt increments.
- LFSR usage: pattern k≥1 uses the LFSR value present after k-1 steps. Pattern 1 is therefore SEED_A / SEED_B with cin=1.
- CMP (1 cycle): pass <= (MISR == GOLDEN_SIG), then DONE. The MISR is not updated in CMP.
- start while busy: ignored, with no restart and no queuing.
- Adder inputs are not checked for X. Any X propagates into the signature.

## Timing
- Operands are registered. The adder settles within the same cycle, and the response is captured at the next rising edge.
- start edge → SEED; operands of pattern 0 are visible after the SEED edge.
- Run length: from start sampled to done=1 is N_PATTERNS+2 edges (1 SEED, N_PATTERNS RUN, 1 CMP).
- busy rises on the edge after start and falls on the same edge that done rises.
- pattern_cnt never exceeds N_PATTERNS-1; it does not wrap.
- Async reset mid-run returns to IDLE immediately. The next start re-seeds everything; no state carries over.
- start asserted together with reset deassertion: start is sampled at the first clean edge, in IDLE.

## Test plan
- N_PATTERNS=1, ideal adder:
  - start → op_a=FFFF_FFFF, op_b=0, op_cin=1.
  - Response {1, 32'h0}.
  - signature=33'h1_0000_0000, pass=1, done=1 exactly 3 edges after start is sampled.
- N_PATTERNS=1, adder with stuck-at-0 on the carry between bit 15 and bit 16:
  - sum=32'hFFFF_0000, cout=0.
  - signature=33'h0_FFFF_0000, pass=0.
- N_PATTERNS=256, ideal adder:
  - op_a/op_b/op_cin match the LFSR reference model on every RUN cycle.
  - Final signature matches the reference model; pass matches GOLDEN_SIG compare.
  - busy high for 258 cycles.
- Reset mid-RUN at pattern_cnt=100:
  - All outputs return to 0 asynchronously, state IDLE.
  - Restart gives a signature identical to an uninterrupted run.
- start pulsed during RUN: no effect on pattern_cnt or signature.
- start in DONE: re-runs and gives the same signature as the previous run.
